// File: rtl/divider_pkg.sv
// ============================================================================
// Module   : divider_pkg
// Brief    : Shared state encoding and sizing for the restoring divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

package divider_pkg;

   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int DIV_WIDTH_DEF = 4;
   localparam int DIV_CNT_W     = cnt_width(DIV_WIDTH_DEF);

   localparam int         ST_W    = 2;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/trial_subtractor.sv
// ============================================================================
// Module   : trial_subtractor
// Brief    : Combinational N-bit ripple-borrow subtractor (a - b - bin).
// Revision : 1.0
// ============================================================================
`default_nettype none

module trial_subtractor #(
   parameter int N = 5
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_bin,
   output logic [N-1:0] o_diff,
   output logic         o_bout
);

   logic [N:0] w_borrow;

   assign w_borrow[0] = i_bin;

   generate
      for (genvar i = 0; i < N; i++) begin : g_bit
         assign o_diff[i]     = i_a[i] ^ i_b[i] ^ w_borrow[i];
         assign w_borrow[i+1] = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_borrow[i]);
      end
   endgenerate

   assign o_bout = w_borrow[N];

endmodule

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
// ============================================================================
// Module   : seq_restoring_divider
// Brief    : Unsigned sequential restoring divider, one quotient bit per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_restoring_divider
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int            CW          = cnt_width(WIDTH);
   localparam logic [CW-1:0] c_LAST_STEP = CW'(WIDTH - 1);

   logic [ST_W-1:0]  r_state;
   logic [ST_W-1:0]  w_next_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic             r_dbz;

   logic             w_accept;
   logic             w_dvs_zero;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic             w_borrow;
   logic             w_restore;

   assign w_accept   = start & ~busy;
   assign w_dvs_zero = (divisor == '0);

   // Quotient register doubles as the dividend shifter: its MSB feeds R.
   assign w_shift = {r_rem, r_quo[WIDTH-1]};

   trial_subtractor #(
      .N (WIDTH + 1)
   ) u_trial_sub (
      .i_a    (w_shift),
      .i_b    ({1'b0, r_dvs}),
      .i_bin  (1'b0),
      .o_diff (w_trial),
      .o_bout (w_borrow)
   );

   // A set trial MSB can only accompany a borrow, so it never changes the decision.
   assign w_restore = w_borrow | w_trial[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state = w_dvs_zero ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (r_cnt == c_LAST_STEP) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               w_next_state = w_dvs_zero ? ST_DONE : ST_RUN;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         ST_RUN:  busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_rem <= '0;
         r_quo <= '0;
         r_dvs <= '0;
         r_dbz <= 1'b0;
      end else if (w_accept) begin
         r_cnt <= '0;
         r_dbz <= w_dvs_zero;
         if (w_dvs_zero) begin
            r_quo <= '1;
            r_rem <= dividend;
         end else begin
            r_quo <= dividend;
            r_rem <= '0;
            r_dvs <= divisor;
         end
      end else if (r_state == ST_RUN) begin
         r_cnt <= r_cnt + 1'b1;
         r_quo <= {r_quo[WIDTH-2:0], ~w_restore};
         r_rem <= w_restore ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
      end
   end

   assign quotient    = r_quo;
   assign remainder   = r_rem;
   assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
// ============================================================================
// Module   : tb_seq_restoring_divider
// Brief    : Scoreboard bench for seq_restoring_divider at the default width.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_restoring_divider;

   localparam int W = 4;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } exp_t;

   logic         clk      = 1'b0;
   logic         rst_n    = 1'b0;
   logic         start    = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor  = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      if (b == '0) begin
         e.q = '1; e.r = a; e.dbz = 1'b1;
      end else begin
         e.q = a / b; e.r = a % b; e.dbz = 1'b0;
      end
      return e;
   endfunction

   task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      sb_q.push_back(ref_div(a, b));
   endtask

   // Waits (bounded) for done; reports latency and how many busy cycles were seen.
   task automatic wait_done(input string tag, input int exp_lat, output int busy_cycles);
      int n;
      n = 0;
      busy_cycles = 0;
      do begin
         @(negedge clk);
         n++;
         if (busy) busy_cycles++;
      end while (!done && n < 20);
      check_eq(tag, n, exp_lat);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         check_eq("busy_with_done", {31'd0, busy}, 0);
         if (sb_q.size() == 0) begin
            check_eq("unexpected_done", {31'd0, done}, 0);
         end else begin
            e = sb_q.pop_front();
            check_eq("quotient",    quotient,    e.q);
            check_eq("remainder",   remainder,   e.r);
            check_eq("div_by_zero", div_by_zero, e.dbz);
         end
      end
   end

   initial begin
      int bc;
      int n;
      int cnt;
      logic [W-1:0] prev_dvs;

      repeat (2) @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_quotient", quotient, 0);
      check_eq("rst_remainder", remainder, 0);
      check_eq("rst_dbz", div_by_zero, 0);
      rst_n = 1'b1;

      // First edge after reset release must accept.
      drive_op(4'd13, 4'd3);
      @(posedge clk); #1 start = 1'b0;
      wait_done("lat_13_3", 5, bc);
      check_eq("busy_cycles_13_3", bc, 4);

      drive_op(4'd2, 4'd9);
      @(posedge clk); #1 start = 1'b0;
      wait_done("lat_2_9", 5, bc);

      drive_op(4'd15, 4'd1);
      @(posedge clk); #1 start = 1'b0;
      wait_done("lat_15_1", 5, bc);

      drive_op(4'd7, 4'd0);
      @(posedge clk); #1 start = 1'b0;
      wait_done("lat_7_0", 1, bc);
      check_eq("busy_cycles_7_0", bc, 0);

      // Start pulsed mid-RUN must be ignored.
      @(negedge clk);
      drive_op(4'd13, 4'd3);
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 start = 1'b1; dividend = 4'd9; divisor = 4'd2;
      @(posedge clk); #1 start = 1'b0; dividend = '0; divisor = '0;
      wait_done("lat_ignored_start", 3, bc);
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check_eq("no_extra_done", cnt, 0);

      // Reset during the second RUN cycle.
      drive_op(4'd13, 4'd3);
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_done", done, 0);
      check_eq("abort_quotient", quotient, 0);
      check_eq("abort_remainder", remainder, 0);
      check_eq("abort_dbz", div_by_zero, 0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check_eq("abort_no_done", cnt, 0);
      drive_op(4'd8, 4'd4);
      @(posedge clk); #1 start = 1'b0;
      wait_done("lat_8_4", 5, bc);

      // Exhaustive back-to-back sweep with start held high.
      @(negedge clk);
      drive_op(4'd0, 4'd0);
      prev_dvs = 4'd0;
      for (int p = 1; p <= 256; p++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (busy && n < 20);
         check_eq("sweep_gap", n, (prev_dvs == '0) ? 1 : 5);
         if (p < 256) begin
            drive_op(p[7:4], p[3:0]);
            prev_dvs = p[3:0];
         end else begin
            start = 1'b0;
         end
      end
      repeat (4) @(negedge clk);
      check_eq("sb_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, observed %0d checks expected completion", n_checks);
      $fatal(1, "time limit");
   end

endmodule

`default_nettype wire
